// File: rtl/picorv32_mem_arbiter_pkg.sv
// Shared definitions for the picorv32 memory-port arbiter: FSM state
// encoding, the EBREAK opcode used as timeout read data, and a small
// wrapping-add helper used for round-robin pointer arithmetic.
package picorv32_mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // EBREAK instruction: a fetch that times out traps instead of executing garbage
  localparam logic [31:0] EBREAK_OPCODE = 32'h0010_0073;

  // (base + offset) mod modulus, assuming both operands are already below modulus
  function automatic int wrap_add(input int base, input int offset, input int modulus);
    int sum;
    sum = base + offset;
    return (sum >= modulus) ? (sum - modulus) : sum;
  endfunction

endpackage

// File: rtl/picorv32_rr_pick.sv
// Round-robin requester selection: scans the request vector starting at
// ptr and wrapping around, returning the first requester as a one-hot
// vector and as a binary index. Purely combinational.
module picorv32_rr_pick
  import picorv32_mem_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  logic found;

  // Walk offsets 0..N-1 from ptr; the first requesting slot wins
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == wrap_add(int'(ptr), k, N))) begin
          onehot[j] = 1'b1;
          idx       = IDX_W'(j);
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Shares one picorv32 native memory port among NUM_MASTERS requesters.
// Round-robin grant, a single outstanding transfer, registered request
// path toward memory, and a watchdog that force-completes hung transfers
// with TIMEOUT_RDATA so nothing upstream can deadlock.
module picorv32_mem_arbiter
  import picorv32_mem_arbiter_pkg::*;
#(
  parameter int          NUM_MASTERS    = 2,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_RDATA  = EBREAK_OPCODE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_MASTERS-1:0]   m_valid,
  input  logic [NUM_MASTERS-1:0]   m_instr,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  input  logic [4*NUM_MASTERS-1:0] m_wstrb,
  output logic [NUM_MASTERS-1:0]   m_ready,
  output logic [31:0]              m_rdata,
  output logic                     mem_valid,
  output logic                     mem_instr,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  output logic [NUM_MASTERS-1:0]   grant,
  output logic                     timeout_err
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // Counter must reach TIMEOUT_CYCLES-1; keep at least one bit when the watchdog is off
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  arb_state_t state, state_next;

  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       g_idx;
  logic [WD_W-1:0]        wd_cnt;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   any_req;
  logic                   load;
  logic                   done;
  logic                   timeout_fire;

  logic                   sel_instr;
  logic [31:0]            sel_addr;
  logic [31:0]            sel_wdata;
  logic [3:0]             sel_wstrb;

  assign any_req = |m_valid;

  picorv32_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (m_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // AND-OR mux of the selected master's request fields
  always_comb begin
    sel_instr = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (pick_onehot[j]) begin
        sel_instr = sel_instr | m_instr[j];
        sel_addr  = sel_addr  | m_addr[32*j +: 32];
        sel_wdata = sel_wdata | m_wdata[32*j +: 32];
        sel_wstrb = sel_wstrb | m_wstrb[4*j +: 4];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the combinational completion path back to the masters
  always_comb begin
    state_next   = state;
    load         = 1'b0;
    done         = 1'b0;
    timeout_fire = 1'b0;
    m_ready      = '0;
    m_rdata      = '0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          load       = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        m_rdata = mem_rdata;
        if (mem_ready) begin
          m_ready    = grant;
          done       = 1'b1;
          state_next = ST_IDLE;
        end else if (WD_EN && (wd_cnt == WD_LAST)) begin
          m_ready      = grant;
          m_rdata      = TIMEOUT_RDATA;
          timeout_fire = 1'b1;
          done         = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registered request path, grant bookkeeping, round-robin pointer and watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid   <= 1'b0;
      mem_instr   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      grant       <= '0;
      g_idx       <= '0;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_fire;
      if (load) begin
        mem_valid <= 1'b1;
        mem_instr <= sel_instr;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        mem_wstrb <= sel_wstrb;
        grant     <= pick_onehot;
        g_idx     <= pick_idx;
        wd_cnt    <= '0;
      end else if (done) begin
        mem_valid <= 1'b0;
        grant     <= '0;
        rr_ptr    <= IDX_W'(wrap_add(int'(g_idx), 1, NUM_MASTERS));
      end else if ((state == ST_BUSY) && (wd_cnt != WD_MAX)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed bench for picorv32_mem_arbiter with two masters and a short
// four-cycle watchdog. Inputs change 1 time unit after each rising edge
// and outputs are compared before the next edge.
module tb_picorv32_mem_arbiter;

  localparam int N = 2;

  logic          clk;
  logic          reset;
  logic [N-1:0]  m_valid;
  logic [N-1:0]  m_instr;
  logic [32*N-1:0] m_addr;
  logic [32*N-1:0] m_wdata;
  logic [4*N-1:0]  m_wstrb;
  logic [N-1:0]  m_ready;
  logic [31:0]   m_rdata;
  logic          mem_valid;
  logic          mem_instr;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [N-1:0]  grant;
  logic          timeout_err;

  int checks;
  int errors;

  picorv32_mem_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_RDATA  (32'h0010_0073)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m_valid     (m_valid),
    .m_instr     (m_instr),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_ready     (m_ready),
    .m_rdata     (m_rdata),
    .mem_valid   (mem_valid),
    .mem_instr   (mem_instr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants checked on every falling edge outside reset
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("[TB] FAIL inv_grant_onehot0: got %b, expected at most one bit", grant);
      end
      checks++;
      if ((m_ready & ~grant) !== '0) begin
        errors++;
        $display("[TB] FAIL inv_ready_subset: got m_ready=%b grant=%b, expected m_ready within grant", m_ready, grant);
      end
      checks++;
      if (mem_valid && (grant == '0)) begin
        errors++;
        $display("[TB] FAIL inv_valid_grant: got mem_valid=1 grant=%b, expected nonzero grant", grant);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int idx, input logic instr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
    m_instr[idx]          = instr;
    m_addr[32*idx +: 32]  = addr;
    m_wdata[32*idx +: 32] = wdata;
    m_wstrb[4*idx +: 4]   = wstrb;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    m_valid   = '0;
    m_instr   = '0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5_5A5A;
    tick();
    tick();
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_valid: got %b, expected 0", mem_valid); end
    checks++;
    if (grant !== 2'b00) begin errors++; $display("[TB] FAIL reset_grant: got %b, expected 00", grant); end
    checks++;
    if (m_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_m_ready: got %b, expected 00", m_ready); end
    checks++;
    if (m_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_m_rdata: got %h, expected 00000000", m_rdata); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err: got %b, expected 0", timeout_err); end
    checks++;
    if ({mem_instr, mem_addr, mem_wdata, mem_wstrb} !== 69'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem_fields: got instr=%b addr=%h wdata=%h wstrb=%h, expected all 0",
               mem_instr, mem_addr, mem_wdata, mem_wstrb);
    end
    reset     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    tick();
  endtask

  task automatic test_single_read();
    set_master(0, 1'b0, 32'h0000_0100, 32'h0, 4'b0000);
    m_valid = 2'b01;
    #1;
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL read_valid_before_edge: got %b, expected 0", mem_valid); end
    tick();
    checks++;
    if (mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL read_mem_valid: got %b, expected 1", mem_valid); end
    checks++;
    if (mem_addr !== 32'h0000_0100) begin errors++; $display("[TB] FAIL read_mem_addr: got %h, expected 00000100", mem_addr); end
    checks++;
    if (grant !== 2'b01) begin errors++; $display("[TB] FAIL read_grant: got %b, expected 01", grant); end
    checks++;
    if (m_ready !== 2'b00) begin errors++; $display("[TB] FAIL read_no_early_ready: got %b, expected 00", m_ready); end
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (m_ready !== 2'b01) begin errors++; $display("[TB] FAIL read_m_ready: got %b, expected 01", m_ready); end
    checks++;
    if (m_rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL read_m_rdata: got %h, expected cafef00d", m_rdata); end
    tick();
    m_valid   = 2'b00;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00) begin errors++; $display("[TB] FAIL read_grant_release: got %b, expected 00", grant); end
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL read_valid_release: got %b, expected 0", mem_valid); end
    checks++;
    if (m_ready !== 2'b00) begin errors++; $display("[TB] FAIL read_ready_release: got %b, expected 00", m_ready); end
    tick();
  endtask

  task automatic test_write();
    set_master(1, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011);
    m_valid = 2'b10;
    tick();
    checks++;
    if (grant !== 2'b10) begin errors++; $display("[TB] FAIL write_grant: got %b, expected 10", grant); end
    checks++;
    if (mem_wstrb !== 4'b0011) begin errors++; $display("[TB] FAIL write_wstrb: got %b, expected 0011", mem_wstrb); end
    checks++;
    if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL write_wdata: got %h, expected deadbeef", mem_wdata); end
    checks++;
    if (mem_addr !== 32'h0000_0200) begin errors++; $display("[TB] FAIL write_addr: got %h, expected 00000200", mem_addr); end
    checks++;
    if (m_ready !== 2'b00) begin errors++; $display("[TB] FAIL write_no_early_ready: got %b, expected 00", m_ready); end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (m_ready !== 2'b10) begin errors++; $display("[TB] FAIL write_m_ready: got %b, expected 10", m_ready); end
    tick();
    m_valid   = 2'b00;
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    logic [1:0] exp_grant [8];
    exp_grant = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    set_master(0, 1'b1, 32'h0000_1000, 32'h0, 4'b0000);
    set_master(1, 1'b0, 32'h0000_2000, 32'h0, 4'b0000);
    m_valid   = 2'b11;
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (grant !== exp_grant[i]) begin
        errors++;
        $display("[TB] FAIL alt_grant[%0d]: got %b, expected %b", i, grant, exp_grant[i]);
      end
      checks++;
      if (m_ready !== exp_grant[i]) begin
        errors++;
        $display("[TB] FAIL alt_m_ready[%0d]: got %b, expected %b", i, m_ready, exp_grant[i]);
      end
      checks++;
      if (mem_valid !== (exp_grant[i] != 2'b00)) begin
        errors++;
        $display("[TB] FAIL alt_mem_valid[%0d]: got %b, expected %b", i, mem_valid, exp_grant[i] != 2'b00);
      end
    end
    m_valid   = 2'b00;
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    set_master(0, 1'b1, 32'h0000_0300, 32'h0, 4'b0000);
    m_valid = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (m_ready !== 2'b00) begin errors++; $display("[TB] FAIL to_early_ready[%0d]: got %b, expected 00", c, m_ready); end
    end
    checks++;
    if (mem_instr !== 1'b1) begin errors++; $display("[TB] FAIL to_mem_instr: got %b, expected 1", mem_instr); end
    tick();
    checks++;
    if (m_ready !== 2'b01) begin errors++; $display("[TB] FAIL to_m_ready: got %b, expected 01", m_ready); end
    checks++;
    if (m_rdata !== 32'h0010_0073) begin errors++; $display("[TB] FAIL to_m_rdata: got %h, expected 00100073", m_rdata); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL to_err_early: got %b, expected 0", timeout_err); end
    tick();
    m_valid = 2'b00;
    #1;
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL to_err_pulse: got %b, expected 1", timeout_err); end
    checks++;
    if ({mem_valid, grant} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL to_release: got mem_valid=%b grant=%b, expected 0 and 00", mem_valid, grant);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL to_err_one_cycle: got %b, expected 0", timeout_err); end
  endtask

  task automatic test_timeout_vs_ready();
    set_master(0, 1'b0, 32'h0000_0400, 32'h0, 4'b0000);
    m_valid = 2'b01;
    for (int c = 1; c <= 4; c++) tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (m_ready !== 2'b01) begin errors++; $display("[TB] FAIL race_m_ready: got %b, expected 01", m_ready); end
    checks++;
    if (m_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL race_m_rdata: got %h, expected 12345678", m_rdata); end
    tick();
    m_valid   = 2'b00;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL race_no_err: got %b, expected 0", timeout_err); end
    checks++;
    if (grant !== 2'b00) begin errors++; $display("[TB] FAIL race_grant_release: got %b, expected 00", grant); end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    set_master(0, 1'b0, 32'h0000_0500, 32'h0, 4'b0000);
    set_master(1, 1'b0, 32'h0000_0600, 32'h0, 4'b0000);
    m_valid = 2'b10;
    tick();
    checks++;
    if (grant !== 2'b10) begin errors++; $display("[TB] FAIL rst_pre_grant: got %b, expected 10", grant); end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_valid: got %b, expected 0", mem_valid); end
    checks++;
    if (grant !== 2'b00) begin errors++; $display("[TB] FAIL rst_async_grant: got %b, expected 00", grant); end
    tick();
    reset   = 1'b0;
    m_valid = 2'b11;
    tick();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("[TB] FAIL rst_first_grant: got %b, expected 01", grant); end
    checks++;
    if (mem_addr !== 32'h0000_0500) begin errors++; $display("[TB] FAIL rst_first_addr: got %h, expected 00000500", mem_addr); end
    mem_ready = 1'b1;
    tick();
    m_valid   = 2'b00;
    mem_ready = 1'b0;
    tick();
  endtask

  // Scenario sequence
  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] starting picorv32_mem_arbiter bench");
    test_reset();
    test_single_read();
    test_write();
    test_alternate();
    test_timeout();
    test_timeout_vs_ready();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
